// File: rtl/bram_cmd_sequencer.sv
// rtl/bram_cmd_sequencer.sv - decodes header/address/payload byte commands from the FIFO into BRAM bursts
module bram_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_mem,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  typedef enum logic [3:0] {
    IDLE, HDR, ADDR_POP, ADDR, DATA_POP, DATA, BWRITE, BREAD, BWAIT, RESP
  } state_t;

  state_t                r_state, w_state_next;
  logic                  r_is_write;
  logic [5:0]            r_beats;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [CNT_WIDTH-1:0]  r_wr_count, r_rd_count, r_err_count;
  logic                  w_hdr_legal;
  logic                  w_more_beats;

  // Only 10 (write) and 01 (read) opcodes are legal.
  assign w_hdr_legal  = fifo_data[7] ^ fifo_data[6];
  assign w_more_beats = (r_beats != 6'd0);

  assign bram_addr  = r_addr;
  assign bram_wdata = r_wdata;
  assign rd_data    = r_rd_data;
  assign wr_count   = r_wr_count;
  assign rd_count   = r_rd_count;
  assign err_count  = r_err_count;

  always_ff @(posedge clk_mem or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    fifo_r_en    = 1'b0;
    bram_en      = 1'b0;
    bram_we      = 1'b0;
    rd_valid     = 1'b0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_r_en    = 1'b1;
          w_state_next = HDR;
        end
      end
      HDR:      w_state_next = w_hdr_legal ? ADDR_POP : IDLE;
      ADDR_POP: begin
        if (!fifo_empty) begin
          fifo_r_en    = 1'b1;
          w_state_next = ADDR;
        end
      end
      ADDR:     w_state_next = r_is_write ? DATA_POP : BREAD;
      DATA_POP: begin
        if (!fifo_empty) begin
          fifo_r_en    = 1'b1;
          w_state_next = DATA;
        end
      end
      DATA:     w_state_next = BWRITE;
      BWRITE: begin
        bram_en      = 1'b1;
        bram_we      = 1'b1;
        w_state_next = w_more_beats ? DATA_POP : IDLE;
      end
      BREAD: begin
        bram_en      = 1'b1;
        w_state_next = BWAIT;
      end
      BWAIT:    w_state_next = RESP;
      RESP: begin
        rd_valid = 1'b1;
        if (rd_ready) w_state_next = w_more_beats ? BREAD : IDLE;
      end
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_mem or posedge reset) begin
    if (reset) begin
      r_is_write  <= 1'b0;
      r_beats     <= 6'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd_data   <= '0;
      r_wr_count  <= '0;
      r_rd_count  <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        HDR: begin
          if (w_hdr_legal) begin
            r_is_write <= fifo_data[7];
            r_beats    <= fifo_data[5:0];
          end else if (r_err_count != '1) begin
            r_err_count <= r_err_count + 1'b1;
          end
        end
        ADDR:  r_addr  <= ADDR_WIDTH'(fifo_data);
        DATA:  r_wdata <= fifo_data;
        BWRITE: begin
          if (r_wr_count != '1) r_wr_count <= r_wr_count + 1'b1;
          if (w_more_beats) begin
            r_addr  <= r_addr + 1'b1;
            r_beats <= r_beats - 1'b1;
          end
        end
        BWAIT: r_rd_data <= bram_rdata;
        // rd_data stays frozen in RESP until the consumer takes it.
        RESP: begin
          if (rd_ready) begin
            if (r_rd_count != '1) r_rd_count <= r_rd_count + 1'b1;
            if (w_more_beats) begin
              r_addr  <= r_addr + 1'b1;
              r_beats <= r_beats - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_cmd_sequencer.sv
// tb/tb_bram_cmd_sequencer.sv - scoreboard bench for bram_cmd_sequencer
module tb_bram_cmd_sequencer;

  logic        clk_mem = 1'b0;
  logic        reset   = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data  = 8'h00;
  logic        fifo_r_en;
  logic        bram_en, bram_we;
  logic [7:0]  bram_addr, bram_wdata;
  logic [7:0]  bram_rdata = 8'h00;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        busy;
  logic [15:0] wr_count, rd_count, err_count;

  bram_cmd_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_mem(clk_mem), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .busy(busy), .wr_count(wr_count), .rd_count(rd_count),
    .err_count(err_count)
  );

  always #5 clk_mem = ~clk_mem;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  logic [7:0]  fq[$];
  logic [15:0] wr_exp[$];
  logic [7:0]  rd_exp[$];
  logic [7:0]  exp_mem [256];
  logic [7:0]  mem [256];
  logic        pop_pend;
  int          exp_wr = 0, exp_rd = 0, exp_err = 0;
  int          n_bram = 0, n_rdv = 0, n_hs = 0;
  logic [15:0] w_e;
  logic [7:0]  r_e;

  // FIFO model: data shows up the cycle after a pop.
  always @(posedge clk_mem or posedge reset) begin
    if (reset) pop_pend <= 1'b0;
    else       pop_pend <= fifo_r_en && !fifo_empty;
  end

  always @(negedge clk_mem) begin
    if (pop_pend && fq.size() > 0) fifo_data <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  always @(posedge clk_mem) begin
    if (bram_en && bram_we)  mem[bram_addr] <= bram_wdata;
    if (bram_en && !bram_we) bram_rdata <= mem[bram_addr];
  end

  always @(negedge clk_mem) begin
    if (!reset) begin
      if (bram_en)  n_bram++;
      if (rd_valid) n_rdv++;
      if (bram_en && bram_we) begin
        if (wr_exp.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          w_e = wr_exp.pop_front();
          check("wr_addr", bram_addr, w_e[15:8]);
          check("wr_data", bram_wdata, w_e[7:0]);
        end
      end
      if (rd_valid && rd_ready) begin
        n_hs++;
        if (rd_exp.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          r_e = rd_exp.pop_front();
          check("rd_data", rd_data, r_e);
        end
      end
    end
  end

  task automatic cmd_write(input logic [7:0] a, input int len, input logic [7:0] d0, input logic [7:0] step);
    logic [7:0] ad, d;
    fq.push_back({2'b10, 6'(len - 1)});
    fq.push_back(a);
    for (int i = 0; i < len; i++) begin
      ad = a + 8'(i);
      d  = d0 + step * 8'(i);
      fq.push_back(d);
      exp_mem[ad] = d;
      wr_exp.push_back({ad, d});
      exp_wr++;
    end
  endtask

  task automatic cmd_read(input logic [7:0] a, input int len);
    logic [7:0] ad;
    fq.push_back({2'b01, 6'(len - 1)});
    fq.push_back(a);
    for (int i = 0; i < len; i++) begin
      ad = a + 8'(i);
      rd_exp.push_back(exp_mem[ad]);
      exp_rd++;
    end
  endtask

  task automatic wait_idle();
    int stable = 0;
    for (int i = 0; i < 2000 && stable < 3; i++) begin
      @(negedge clk_mem);
      if (fq.size() == 0 && !busy) stable++;
      else stable = 0;
    end
    if (stable < 3) check("idle_timeout", 0, 1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_wr_count"},  wr_count,  exp_wr);
    check({tag, "_rd_count"},  rd_count,  exp_rd);
    check({tag, "_err_count"}, err_count, exp_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fifo_r_en"}, fifo_r_en, 0);
    check({tag, "_bram_en"},   bram_en,   0);
    check({tag, "_bram_we"},   bram_we,   0);
    check({tag, "_rd_valid"},  rd_valid,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_bram_addr"}, bram_addr, 0);
    check({tag, "_bram_wdata"}, bram_wdata, 0);
    check({tag, "_rd_data"},   rd_data,   0);
    check({tag, "_counters"},  {wr_count | rd_count | err_count}, 0);
  endtask

  initial begin
    int base, cnt;
    logic [7:0] held;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'h00;
      exp_mem[i] = 8'h00;
    end
    repeat (3) @(negedge clk_mem);
    check_all_zero("reset");
    @(posedge clk_mem); #1 reset = 1'b0;

    // single write then single read
    cmd_write(8'h10, 1, 8'hA5, 8'h00);
    cmd_read(8'h10, 1);
    wait_idle();
    check("single_rdv_cycles", n_rdv, 1);
    check_counts("single");

    // burst wrapping FE..01
    cmd_write(8'hFE, 4, 8'h11, 8'h11);
    cmd_read(8'hFE, 4);
    wait_idle();
    check_counts("burst");

    // back-pressure on the read response
    @(posedge clk_mem); #1 rd_ready = 1'b0;
    cmd_read(8'hFE, 2);
    for (int i = 0; i < 100 && !rd_valid; i++) @(negedge clk_mem);
    if (!rd_valid) check("rdv_timeout", 0, 1);
    held = rd_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_mem);
      check("stall_rd_valid", rd_valid, 1);
      check("stall_rd_data",  rd_data,  held);
      check("stall_bram_en",  bram_en,  0);
    end
    @(posedge clk_mem); #1 rd_ready = 1'b1;
    wait_idle();
    check_counts("backpressure");

    // illegal header followed by a normal write
    base = n_bram;
    fq.push_back(8'hC0);
    exp_err++;
    cmd_write(8'h20, 1, 8'h5A, 8'h00);
    wait_idle();
    check("illegal_bram_accesses", n_bram - base, 1);
    check_counts("illegal");

    // FIFO runs dry between address and data
    fq.push_back(8'h80);
    fq.push_back(8'h30);
    for (int i = 0; i < 100 && fq.size() != 0; i++) @(negedge clk_mem);
    repeat (3) @(negedge clk_mem);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_mem);
      check("dry_fifo_r_en", fifo_r_en, 0);
      check("dry_bram_en",   bram_en,   0);
      check("dry_busy",      busy,      1);
    end
    exp_mem[8'h30] = 8'h77;
    wr_exp.push_back({8'h30, 8'h77});
    exp_wr++;
    fq.push_back(8'h77);
    wait_idle();
    check_counts("dry");

    // reset during the third beat of a 4-beat read
    cmd_write(8'h00, 4, 8'h10, 8'h10);
    wait_idle();
    base = n_hs;
    cmd_read(8'h00, 4);
    for (int i = 0; i < 200 && (n_hs - base) < 2; i++) @(negedge clk_mem);
    cnt = 0;
    for (int i = 0; i < 20 && !bram_en; i++) begin
      @(negedge clk_mem);
      cnt++;
    end
    if (!bram_en) check("third_beat_timeout", 0, 1);
    reset = 1'b1;
    #1;
    check_all_zero("midburst_reset");
    fq.delete();
    wr_exp.delete();
    rd_exp.delete();
    exp_wr = 0; exp_rd = 0; exp_err = 0;
    repeat (2) @(negedge clk_mem);
    @(posedge clk_mem); #1 reset = 1'b0;
    @(negedge clk_mem);
    check("post_reset_busy", busy, 0);
    cmd_read(8'h00, 1);
    wait_idle();
    check_counts("post_reset");
    check("wr_exp_left", wr_exp.size(), 0);
    check("rd_exp_left", rd_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_cmd_sequencer.md
Name: bram_cmd_sequencer

Overview:
- Single-clock controller on the memory side of the asynchronous FIFO.
- Pops byte-wide command streams from the FIFO read port, decodes them, and sequences burst writes and reads into the BRAM.
- Returns read data to the consumer over a valid/ready handshake.
- Replaces direct wiring of FIFO data to BRAM address/data with an explicit header/address/data protocol.

Parameters:
- DATA_WIDTH, 8, FIFO/BRAM data width; header layout below requires exactly 8.
- ADDR_WIDTH, 8, BRAM address width.
- CNT_WIDTH, 16, width of the transaction and error counters.

Ports:
- clk_mem  in  1  memory-domain clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO read-side empty flag.
- fifo_data  in  DATA_WIDTH  FIFO read data; valid the cycle after a pop (fifo_r_en=1 while fifo_empty=0).
- fifo_r_en  out  1  FIFO pop request.
- bram_en  out  1  BRAM access strobe.
- bram_we  out  1  1 = write, 0 = read; meaningful only with bram_en.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_wdata  out  DATA_WIDTH  BRAM write data.
- bram_rdata  in  DATA_WIDTH  BRAM read data; registered, valid one cycle after the read strobe.
- rd_data  out  DATA_WIDTH  read response data.
- rd_valid  out  1  read response valid.
- rd_ready  in  1  consumer accepts the response.
- busy  out  1  high whenever state is not IDLE.
- wr_count  out  CNT_WIDTH  completed BRAM writes; saturating.
- rd_count  out  CNT_WIDTH  accepted read responses; saturating.
- err_count  out  CNT_WIDTH  illegal headers; saturating.

Behaviour:
- Command format: header byte, then address byte, then payload.
  - header[7:6] = 10: write. header[7:6] = 01: read. 00 or 11: illegal.
  - header[5:0] = LEN-1, so LEN ranges 1..64.
  - Write payload is LEN data bytes; read has no payload.
- Burst addressing: address increments by 1 per beat and wraps modulo 2^ADDR_WIDTH (0xFF -> 0x00).
- Pop rule: fifo_r_en = 1 only in IDLE, ADDR_POP and DATA_POP, and only when fifo_empty = 0. It is combinational from state and fifo_empty and is never asserted while empty. When the FIFO is empty the state holds; there is no timeout.
- State machine:
  - IDLE: pop when not empty, then go to HDR.
  - HDR: capture fifo_data.
    - Illegal header: err_count += 1, go to IDLE; the next byte is treated as a new header.
    - Legal header: load beat counter = LEN-1, go to ADDR_POP.
  - ADDR_POP -> ADDR: capture address. Write goes to DATA_POP; read goes to BREAD.
  - DATA_POP -> DATA: capture the data byte, go to BWRITE.
  - BWRITE: one cycle with bram_en=1, bram_we=1, bram_addr=current address, bram_wdata=captured byte. wr_count += 1. If beats remain: address+1, count-1, go to DATA_POP; otherwise go to IDLE.
  - BREAD: one cycle with bram_en=1, bram_we=0. Go to BWAIT.
  - BWAIT: capture bram_rdata into rd_data. Go to RESP.
  - RESP: rd_valid=1; rd_data held stable until rd_valid && rd_ready. On that handshake, rd_count += 1. If beats remain: address+1, count-1, go to BREAD; otherwise go to IDLE.
- Timing:
  - Single write: 6 cycles, header pop to BWRITE, with a non-empty FIFO.
  - Single read: 6 cycles, header pop to first rd_valid.
- bram_en is 0 in every state other than BWRITE and BREAD. This includes all stall states.
- rd_valid never drops without a handshake. rd_ready is ignored when rd_valid = 0.
- Counters saturate at all-ones and do not wrap.
- Reset (at any time, including mid-burst):
  - State returns to IDLE.
  - fifo_r_en, bram_en, bram_we, rd_valid and busy go to 0.
  - bram_addr, bram_wdata, rd_data and all counters go to 0.
  - A partially consumed command is discarded; the FIFO is reset by the same signal.

Test Plan:
- Write 0x80,0x10,0xA5, then read 0x40,0x10 with rd_ready=1 -> one BWRITE at addr 0x10 data 0xA5; rd_data=0xA5 with rd_valid high one cycle; wr_count=1, rd_count=1.
- Burst write 0x83,0xFE,0x11,0x22,0x33,0x44, then burst read 0x43,0xFE -> writes to addresses FE,FF,00,01; responses 11,22,33,44 in order, showing address wrap.
- Read response with rd_ready held 0 for 5 cycles -> rd_valid stays 1, rd_data stable, no further bram_en; the next beat is issued only after the handshake.
- Illegal header 0xC0, then 0x80,0x20,0x5A -> err_count=1, no BRAM access for 0xC0; the write to 0x20 completes normally.
- Write command with fifo_empty=1 for 4 cycles between the address and data bytes -> FSM holds in DATA_POP, fifo_r_en=0, bram_en=0; the write completes once the data byte arrives.
- Reset asserted during the 3rd beat of a 4-beat read -> all outputs 0 immediately; after release, busy=0 and a fresh 0x40,0x00 command executes correctly.
